// File: rtl/lcplc_tagger_pkg.sv
// Shared types and default sizes for the LCPLC cube tagger.
package lcplc_tagger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_DIM_WIDTH   = 8;
    localparam int DEF_BAND_WIDTH  = 10;
    localparam int DEF_SLICE_WIDTH = 12;

endpackage

// File: rtl/wrap_counter.sv
// Counter that advances on enable and wraps to zero after reaching limit.
module wrap_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_limit = (count_q == limit);
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = at_limit ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axis_cube_tagger.sv
// Tags a raw AXIS sample stream with row/slice/band/image last flags,
// through a one-deep output register slice.
module axis_cube_tagger
    import lcplc_tagger_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DIM_WIDTH   = DEF_DIM_WIDTH,
    parameter int BAND_WIDTH  = DEF_BAND_WIDTH,
    parameter int SLICE_WIDTH = DEF_SLICE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DIM_WIDTH-1:0]   cfg_width,
    input  logic [DIM_WIDTH-1:0]   cfg_height,
    input  logic [BAND_WIDTH-1:0]  cfg_bands,
    input  logic [SLICE_WIDTH-1:0] cfg_slices,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   x_valid,
    input  logic                   x_ready,
    output logic [DATA_WIDTH-1:0]  x_data,
    output logic                   x_last_r,
    output logic                   x_last_s,
    output logic                   x_last_b,
    output logic                   x_last_i,
    output logic                   busy,
    output logic                   err_last
);

    state_e                 state_q, state_d;
    logic [DIM_WIDTH-1:0]   width_q, width_d;
    logic [DIM_WIDTH-1:0]   height_q, height_d;
    logic [BAND_WIDTH-1:0]  bands_q, bands_d;
    logic [SLICE_WIDTH-1:0] slices_q, slices_d;
    logic                   xv_q, xv_d;
    logic [DATA_WIDTH-1:0]  xd_q, xd_d;
    logic [3:0]             xf_q, xf_d;
    logic                   err_q, err_d;

    logic [DIM_WIDTH-1:0]   col, row;
    logic [BAND_WIDTH-1:0]  band;
    logic [SLICE_WIDTH-1:0] slc;
    logic                   col_at, row_at, band_at, slc_at;
    logic                   en_col, en_row, en_band, en_slc;
    logic                   accept, last_r, last_s, last_b, last_i;

    assign cfg_ready = (state_q == IDLE);
    assign in_ready  = (state_q == RUN) && (!xv_q || x_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);

    assign last_r = (col == width_q);
    assign last_s = last_r && (row == height_q);
    assign last_b = last_s && (band == bands_q);
    assign last_i = last_b && (slc == slices_q);

    // Carry chain: each counter only steps when every faster one wraps.
    assign en_col  = accept;
    assign en_row  = en_col && col_at;
    assign en_band = en_row && row_at;
    assign en_slc  = en_band && band_at;

    wrap_counter #(.WIDTH(DIM_WIDTH)) u_col (
        .clk(clk), .rst(rst), .enable(en_col), .limit(width_q),
        .count(col), .at_limit(col_at)
    );
    wrap_counter #(.WIDTH(DIM_WIDTH)) u_row (
        .clk(clk), .rst(rst), .enable(en_row), .limit(height_q),
        .count(row), .at_limit(row_at)
    );
    wrap_counter #(.WIDTH(BAND_WIDTH)) u_band (
        .clk(clk), .rst(rst), .enable(en_band), .limit(bands_q),
        .count(band), .at_limit(band_at)
    );
    wrap_counter #(.WIDTH(SLICE_WIDTH)) u_slc (
        .clk(clk), .rst(rst), .enable(en_slc), .limit(slices_q),
        .count(slc), .at_limit(slc_at)
    );

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        bands_d  = bands_q;
        slices_d = slices_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    bands_d  = cfg_bands;
                    slices_d = cfg_slices;
                    err_d    = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // The slice counter wrapping is exactly the last image beat.
                if (en_slc && slc_at) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xv_q && x_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept && (in_last != last_i)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        xv_d = xv_q;
        xd_d = xd_q;
        xf_d = xf_q;
        if (accept) begin
            xv_d = 1'b1;
            xd_d = in_data;
            xf_d = {last_i, last_b, last_s, last_r};
        end else if (x_ready) begin
            xv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_q  <= '0;
            height_q <= '0;
            bands_q  <= '0;
            slices_q <= '0;
            xv_q     <= 1'b0;
            xd_q     <= '0;
            xf_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            width_q  <= width_d;
            height_q <= height_d;
            bands_q  <= bands_d;
            slices_q <= slices_d;
            xv_q     <= xv_d;
            xd_q     <= xd_d;
            xf_q     <= xf_d;
            err_q    <= err_d;
        end
    end

    assign x_valid  = xv_q;
    assign x_data   = xd_q;
    assign x_last_r = xf_q[0];
    assign x_last_s = xf_q[1];
    assign x_last_b = xf_q[2];
    assign x_last_i = xf_q[3];
    assign err_last = err_q;

endmodule

// File: tb/tb_axis_cube_tagger.sv
// Self-checking bench for axis_cube_tagger with a positional reference model.
module tb_axis_cube_tagger;

    localparam int DW = 16;
    localparam int MW = 8;
    localparam int BW = 10;
    localparam int SW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [MW-1:0] cfg_width, cfg_height;
    logic [BW-1:0] cfg_bands;
    logic [SW-1:0] cfg_slices;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic          x_valid, x_ready;
    logic [DW-1:0] x_data;
    logic          x_last_r, x_last_s, x_last_b, x_last_i;
    logic          busy, err_last;
    wire  [3:0]    xf = {x_last_i, x_last_b, x_last_s, x_last_r};

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    axis_cube_tagger dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_bands(cfg_bands), .cfg_slices(cfg_slices),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .x_last_r(x_last_r), .x_last_s(x_last_s), .x_last_b(x_last_b), .x_last_i(x_last_i),
        .busy(busy), .err_last(err_last)
    );

    // Flags {i,b,s,r} of the k-th sample of an image, from its cube position.
    function automatic logic [3:0] model_flags(int k, int w, int h, int b, int s);
        int nw, nh, nb, ns, col, row, band, sl;
        logic fr, fs, fb, fi;
        nw = w + 1; nh = h + 1; nb = b + 1; ns = s + 1;
        col  = k % nw;
        row  = (k / nw) % nh;
        band = (k / (nw * nh)) % nb;
        sl   = (k / (nw * nh * nb)) % ns;
        fr = (col == nw - 1);
        fs = fr && (row == nh - 1);
        fb = fs && (band == nb - 1);
        fi = fb && (sl == ns - 1);
        return {fi, fb, fs, fr};
    endfunction

    task automatic do_cfg(int w, int h, int b, int s);
        cfg_width  = MW'(w);
        cfg_height = MW'(h);
        cfg_bands  = BW'(b);
        cfg_slices = SW'(s);
        cfg_valid  = 1'b1;
        @(posedge clk); #1;
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready got %b want 1", cfg_ready); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (x_valid !== 1'b0) $display("FAIL rst_x_valid got %b want 0", x_valid); else pass_cnt++;
        total_cnt++; if (x_data !== '0) $display("FAIL rst_x_data got %h want 0", x_data); else pass_cnt++;
        total_cnt++; if (xf !== 4'b0000) $display("FAIL rst_flags got %b want 0000", xf); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (err_last !== 1'b0) $display("FAIL rst_err_last got %b want 0", err_last); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] dat [16];
        logic [3:0]    exp;
        for (int k = 0; k < 16; k++) dat[k] = DW'($urandom);
        x_ready = 1'b1;
        do_cfg(3, 1, 1, 0);
        for (int c = 0; c <= 17; c++) begin
            if (c < 16) begin
                in_valid = 1'b1; in_data = dat[c]; in_last = (c == 15);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clk);
            if (c < 16) begin
                total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready beat %0d got %b want 1", c + 1, in_ready); else pass_cnt++;
            end
            if (c >= 1 && c <= 16) begin
                exp = {c == 16, c == 16, (c % 8) == 0, (c % 4) == 0};
                total_cnt++; if (x_valid !== 1'b1) $display("FAIL basic_x_valid beat %0d got %b want 1", c, x_valid); else pass_cnt++;
                total_cnt++; if (x_data !== dat[c-1]) $display("FAIL basic_x_data beat %0d got %h want %h", c, x_data, dat[c-1]); else pass_cnt++;
                total_cnt++; if (xf !== exp) $display("FAIL basic_flags beat %0d got %b want %b", c, xf, exp); else pass_cnt++;
            end
            if (c == 16) begin
                total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_drain got %b want 1", busy); else pass_cnt++;
            end
            if (c == 17) begin
                total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_idle got %b want 0", busy); else pass_cnt++;
                total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL basic_cfg_ready got %b want 1", cfg_ready); else pass_cnt++;
                total_cnt++; if (x_valid !== 1'b0) $display("FAIL basic_x_valid_end got %b want 0", x_valid); else pass_cnt++;
                total_cnt++; if (err_last !== 1'b0) $display("FAIL basic_err_last got %b want 0", err_last); else pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] dat [16];
        logic [3:0]    pat = 4'b1001;
        logic [3:0]    exp, prev_f;
        logic [DW-1:0] prev_d;
        logic          prev_stall, acc, pop;
        int            sent, recv, cyc;
        for (int k = 0; k < 16; k++) dat[k] = DW'($urandom);
        sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_f = '0;
        do_cfg(3, 1, 1, 0);
        while (recv < 16 && cyc < 200) begin
            x_ready  = pat[2'(cyc % 4)];
            in_valid = (sent < 16);
            in_data  = dat[4'(sent)];
            in_last  = (sent == 15);
            @(negedge clk);
            if (prev_stall) begin
                total_cnt++;
                if (x_valid !== 1'b1 || x_data !== prev_d || xf !== prev_f)
                    $display("FAIL stall_hold cycle %0d got v=%b d=%h f=%b want v=1 d=%h f=%b", cyc, x_valid, x_data, xf, prev_d, prev_f);
                else pass_cnt++;
            end
            if (x_valid && !x_ready) begin
                total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cycle %0d got %b want 0", cyc, in_ready); else pass_cnt++;
            end
            if (x_valid) begin
                total_cnt++;
                if (recv >= 16) $display("FAIL stall_extra beat got d=%h want none", x_data);
                else begin
                    exp = model_flags(recv, 3, 1, 1, 0);
                    if (x_data !== dat[4'(recv)] || xf !== exp)
                        $display("FAIL stall_beat %0d got d=%h f=%b want d=%h f=%b", recv + 1, x_data, xf, dat[4'(recv)], exp);
                    else pass_cnt++;
                end
            end
            acc = in_valid && in_ready;
            pop = x_valid && x_ready;
            prev_stall = x_valid && !x_ready;
            prev_d = x_data;
            prev_f = xf;
            if (pop) recv++;
            if (acc) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; x_ready = 1'b1;
        total_cnt++; if (recv != 16) $display("FAIL stall_count got %0d want 16", recv); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (x_valid !== 1'b0) $display("FAIL stall_no_dup got %b want 0", x_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL stall_idle got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        x_ready = 1'b1;
        for (int img = 0; img < 3; img++) begin
            d = DW'($urandom);
            do_cfg(0, 0, 0, 0);
            in_valid = 1'b1; in_data = d; in_last = 1'b1;
            @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0)
                $display("FAIL single_run img %0d got rdy=%b busy=%b cfg=%b want 1 1 0", img, in_ready, busy, cfg_ready);
            else pass_cnt++;
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0;
            @(negedge clk);
            total_cnt++; if (x_valid !== 1'b1 || x_data !== d) $display("FAIL single_beat img %0d got v=%b d=%h want v=1 d=%h", img, x_valid, x_data, d); else pass_cnt++;
            total_cnt++; if (xf !== 4'b1111) $display("FAIL single_flags img %0d got %b want 1111", img, xf); else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || cfg_ready !== 1'b0)
                $display("FAIL single_drain img %0d got busy=%b rdy=%b cfg=%b want 1 0 0", img, busy, in_ready, cfg_ready);
            else pass_cnt++;
            @(posedge clk); #1;
            @(negedge clk);
            total_cnt++;
            if (busy !== 1'b0 || cfg_ready !== 1'b1 || x_valid !== 1'b0 || err_last !== 1'b0)
                $display("FAIL single_idle img %0d got busy=%b cfg=%b v=%b err=%b want 0 1 0 0", img, busy, cfg_ready, x_valid, err_last);
            else pass_cnt++;
        end
    endtask

    task automatic test_err_last();
        logic [DW-1:0] dat [4];
        for (int k = 0; k < 4; k++) dat[k] = DW'($urandom);
        x_ready = 1'b1;
        do_cfg(1, 0, 0, 1);
        for (int c = 0; c <= 5; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; in_data = dat[c]; in_last = (c == 1);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                total_cnt++; if (x_valid !== 1'b1 || x_data !== dat[c-1]) $display("FAIL err_beat %0d got v=%b d=%h want v=1 d=%h", c, x_valid, x_data, dat[c-1]); else pass_cnt++;
                total_cnt++; if (x_last_i !== (c == 4)) $display("FAIL err_last_i beat %0d got %b want %b", c, x_last_i, c == 4); else pass_cnt++;
                total_cnt++; if (x_last_r !== ((c % 2) == 0)) $display("FAIL err_last_r beat %0d got %b want %b", c, x_last_r, (c % 2) == 0); else pass_cnt++;
                total_cnt++; if (err_last !== (c >= 2)) $display("FAIL err_flag after beat %0d got %b want %b", c, err_last, c >= 2); else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++; if (err_last !== 1'b1 || busy !== 1'b0) $display("FAIL err_sticky got err=%b busy=%b want 1 0", err_last, busy); else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        do_cfg(0, 0, 0, 0);
        @(negedge clk);
        total_cnt++; if (err_last !== 1'b0) $display("FAIL err_clear got %b want 0", err_last); else pass_cnt++;
        in_valid = 1'b1; in_data = '0; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] dat [16];
        logic [3:0]    exp;
        x_ready = 1'b1;
        do_cfg(3, 1, 1, 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = DW'($urandom); in_last = 1'b0;
            @(posedge clk); #1;
        end
        total_cnt++; if (x_valid !== 1'b1) $display("FAIL rmid_pre_valid got %b want 1", x_valid); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (x_valid !== 1'b0 || x_data !== '0 || xf !== 4'b0000) $display("FAIL rmid_x got v=%b d=%h f=%b want 0 0 0000", x_valid, x_data, xf); else pass_cnt++;
        total_cnt++; if (cfg_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL rmid_ctrl got cfg=%b busy=%b rdy=%b want 1 0 0", cfg_ready, busy, in_ready); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++; if (x_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL rmid_no_emit cycle %0d got v=%b rdy=%b want 0 0", c, x_valid, in_ready); else pass_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) dat[k] = DW'($urandom);
        do_cfg(3, 1, 1, 0);
        for (int c = 0; c <= 17; c++) begin
            if (c < 16) begin
                exp = model_flags(c, 3, 1, 1, 0);
                in_valid = 1'b1; in_data = dat[c]; in_last = exp[3];
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            @(negedge clk);
            if (c >= 1 && c <= 16) begin
                exp = model_flags(c - 1, 3, 1, 1, 0);
                total_cnt++;
                if (x_valid !== 1'b1 || x_data !== dat[c-1] || xf !== exp)
                    $display("FAIL rmid_beat %0d got v=%b d=%h f=%b want v=1 d=%h f=%b", c, x_valid, x_data, xf, dat[c-1], exp);
                else pass_cnt++;
            end
            if (c == 17) begin
                total_cnt++; if (busy !== 1'b0 || err_last !== 1'b0) $display("FAIL rmid_end got busy=%b err=%b want 0 0", busy, err_last); else pass_cnt++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int            w, h, b, s, n, sent, recv, cyc;
        logic [DW-1:0] q [$];
        logic [DW-1:0] prev_d;
        logic [3:0]    exp, prev_f;
        logic          prev_stall, acc, pop;
        for (int t = 0; t < 4; t++) begin
            w = $urandom_range(0, 3); h = $urandom_range(0, 2);
            b = $urandom_range(0, 2); s = $urandom_range(0, 1);
            n = (w + 1) * (h + 1) * (b + 1) * (s + 1);
            sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_f = '0;
            q.delete();
            do_cfg(w, h, b, s);
            while (recv < n && cyc < 2000) begin
                x_ready  = ($urandom_range(0, 9) < 7);
                in_valid = (sent < n) && ($urandom_range(0, 9) < 7);
                in_data  = DW'($urandom);
                exp      = model_flags(sent, w, h, b, s);
                in_last  = exp[3];
                @(negedge clk);
                if (prev_stall) begin
                    total_cnt++;
                    if (x_valid !== 1'b1 || x_data !== prev_d || xf !== prev_f)
                        $display("FAIL rand_hold cfg %0d got v=%b d=%h f=%b want v=1 d=%h f=%b", t, x_valid, x_data, xf, prev_d, prev_f);
                    else pass_cnt++;
                end
                if (x_valid) begin
                    total_cnt++;
                    if (q.size() == 0) $display("FAIL rand_extra cfg %0d got d=%h want none", t, x_data);
                    else begin
                        exp = model_flags(recv, w, h, b, s);
                        if (x_data !== q[0] || xf !== exp)
                            $display("FAIL rand_beat cfg %0d idx %0d got d=%h f=%b want d=%h f=%b", t, recv, x_data, xf, q[0], exp);
                        else pass_cnt++;
                    end
                end
                acc = in_valid && in_ready;
                pop = x_valid && x_ready;
                prev_stall = x_valid && !x_ready;
                prev_d = x_data;
                prev_f = xf;
                if (pop && q.size() > 0) begin
                    void'(q.pop_front());
                    recv++;
                end
                if (acc) begin
                    q.push_back(in_data);
                    sent++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            in_valid = 1'b0; in_last = 1'b0; x_ready = 1'b1;
            total_cnt++; if (recv != n) $display("FAIL rand_count cfg %0d got %0d want %0d", t, recv, n); else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (busy !== 1'b0 || err_last !== 1'b0 || x_valid !== 1'b0)
                $display("FAIL rand_end cfg %0d got busy=%b err=%b v=%b want 0 0 0", t, busy, err_last, x_valid);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b0;
        cfg_valid = 1'b0; cfg_width = '0; cfg_height = '0; cfg_bands = '0; cfg_slices = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; x_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_single();
        test_err_last();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish before 2000000");
        $fatal(1, "simulation timeout");
    end

endmodule
